// File: rtl/game_controller.sv
// Finger Dancer round controller: sequences a game, issues finger targets from an LFSR,
// judges each answer window reported by the timing block and keeps score and lives.
module game_controller #(
   parameter logic [3:0] START_RT       = 4'd12,
   parameter logic [3:0] MIN_RT         = 4'd4,
   parameter int         HITS_PER_LEVEL = 4,
   parameter logic [1:0] LIVES          = 2'd3,
   parameter int         INIT_CYCLES    = 4,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] keys,
   input  logic       round_tick,
   output logic       gameState,
   output logic [3:0] roundTime,
   output logic       INIT,
   output logic [3:0] target,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_OVER
   } state_t;

   localparam logic [7:0] LOAD_LAST = 8'(INIT_CYCLES - 1);

   state_t     state_reg, state_next;
   logic [7:0] load_cnt_reg, load_cnt_next;
   logic [7:0] score_reg, score_next;
   logic [1:0] lives_reg, lives_next;
   logic [3:0] target_reg, target_next;
   logic [3:0] round_time_reg, round_time_next;
   logic [7:0] lfsr_reg, lfsr_next;
   logic       tick_q_reg, tick_q_next;
   logic [3:0] keys_q_reg;
   logic       win_reg, win_next;
   logic       cap_reg, cap_next;
   logic [3:0] cap_val_reg, cap_val_next;
   logic       game_state_reg;
   logic       init_reg;
   logic       game_over_reg;

   logic       rise;
   logic       fall;
   logic       press;
   logic [3:0] fresh_target;
   logic [7:0] level;
   logic [3:0] rt_from_score;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running in every state
   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_shift
         assign lfsr_next[gi] = lfsr_reg[gi-1];
      end
   endgenerate
   assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

   assign fresh_target = (lfsr_reg[3:0] == 4'd0) ? 4'd1 : lfsr_reg[3:0];

   // Window shrinks one step per HITS_PER_LEVEL hits, floored at MIN_RT
   always_comb begin
      level         = score_reg / 8'(HITS_PER_LEVEL);
      rt_from_score = START_RT - level[3:0];
      if (({2'b00, level} + {6'd0, MIN_RT}) >= {6'd0, START_RT}) begin
         rt_from_score = MIN_RT;
      end
   end

   always_comb begin
      state_next      = state_reg;
      load_cnt_next   = load_cnt_reg;
      score_next      = score_reg;
      lives_next      = lives_reg;
      target_next     = target_reg;
      win_next        = win_reg;
      cap_next        = cap_reg;
      cap_val_next    = cap_val_reg;
      tick_q_next     = 1'b1;
      round_time_next = rt_from_score;
      rise            = 1'b0;
      fall            = 1'b0;
      press           = 1'b0;

      case (state_reg)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_next    = S_LOAD;
               load_cnt_next = 8'd0;
            end
         end

         S_LOAD: begin
            score_next      = 8'd0;
            lives_next      = LIVES;
            round_time_next = START_RT;
            if (load_cnt_reg == LOAD_LAST) begin
               state_next  = S_PLAY;
               target_next = fresh_target;
               win_next    = 1'b1;
               cap_next    = 1'b0;
            end else begin
               load_cnt_next = load_cnt_reg + 8'd1;
            end
         end

         S_PLAY: begin
            tick_q_next = round_tick;
            rise        = round_tick & ~tick_q_reg;
            fall        = ~round_tick & tick_q_reg;
            // A press on the rising edge belongs to the window that is just opening
            press = (keys != 4'd0) && (keys_q_reg == 4'd0) && round_tick &&
                    (rise || (win_reg && !cap_reg));

            if (rise) begin
               target_next = fresh_target;
               win_next    = 1'b1;
               cap_next    = 1'b0;
            end
            if (press) begin
               cap_next     = 1'b1;
               cap_val_next = keys;
            end
            if (fall && win_reg) begin
               win_next = 1'b0;
               if (cap_reg && (cap_val_reg == target_reg)) begin
                  if (score_reg != 8'hFF) begin
                     score_next = score_reg + 8'd1;
                  end
               end else begin
                  lives_next = lives_reg - 2'd1;
                  if (lives_reg == 2'd1) begin
                     state_next = S_OVER;
                  end
               end
            end
         end

         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         load_cnt_reg   <= 8'd0;
         score_reg      <= 8'd0;
         lives_reg      <= LIVES;
         target_reg     <= 4'd1;
         round_time_reg <= START_RT;
         lfsr_reg       <= LFSR_SEED;
         tick_q_reg     <= 1'b1;
         keys_q_reg     <= 4'd0;
         win_reg        <= 1'b0;
         cap_reg        <= 1'b0;
         cap_val_reg    <= 4'd0;
         game_state_reg <= 1'b0;
         init_reg       <= 1'b1;
         game_over_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         load_cnt_reg   <= load_cnt_next;
         score_reg      <= score_next;
         lives_reg      <= lives_next;
         target_reg     <= target_next;
         round_time_reg <= round_time_next;
         lfsr_reg       <= lfsr_next;
         tick_q_reg     <= tick_q_next;
         keys_q_reg     <= keys;
         win_reg        <= win_next;
         cap_reg        <= cap_next;
         cap_val_reg    <= cap_val_next;
         game_state_reg <= (state_next == S_PLAY);
         init_reg       <= (state_next != S_PLAY);
         game_over_reg  <= (state_next == S_OVER);
      end
   end

   assign gameState = game_state_reg;
   assign INIT      = init_reg;
   assign game_over = game_over_reg;
   assign roundTime = round_time_reg;
   assign target    = target_reg;
   assign score     = score_reg;
   assign lives     = lives_reg;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed game scenarios plus randomized rounds, every cycle
// compared against a rule-level model of the game kept in this file.
`timescale 1ns/1ps
module tb_game_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] keys;
   logic       round_tick;
   logic       gameState;
   logic [3:0] roundTime;
   logic       INIT;
   logic [3:0] target;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over;

   always #5 clk = ~clk;

   game_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .keys       (keys),
      .round_tick (round_tick),
      .gameState  (gameState),
      .roundTime  (roundTime),
      .INIT       (INIT),
      .target     (target),
      .score      (score),
      .lives      (lives),
      .game_over  (game_over)
   );

   localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_OVER = 3;
   localparam int K_HIT = 0, K_NONE = 1, K_WRONG = 2, K_WRONG_RIGHT = 3,
                  K_FALL_PRESS = 4, K_RISE_PRESS = 5;

   int n_cmp = 0;
   int n_bad = 0;
   int n_round = 0;

   // model of the game as the rules describe it
   int         m_phase;
   int         m_score;
   int         m_lives;
   int         m_rt;
   int         m_load_left;
   logic [3:0] m_target;
   logic [7:0] m_lfsr;
   bit         m_prev_tick;
   logic [3:0] m_prev_keys;
   bit         m_open;
   bit         m_got;
   logic [3:0] m_got_val;

   function automatic int rt_rule(input int s);
      int r;
      r = 12 - s / 4;
      return (r < 4) ? 4 : r;
   endfunction

   function automatic logic [3:0] fresh_target();
      logic [3:0] t;
      t = m_lfsr[3:0];
      return (t == 4'd0) ? 4'd1 : t;
   endfunction

   function automatic logic [3:0] wrong_pattern(input logic [3:0] t);
      logic [3:0] w;
      w = 4'($urandom_range(1, 15));
      if (w == t) w = (t == 4'd15) ? 4'd1 : t + 4'd1;
      return w;
   endfunction

   task automatic model_edge();
      int  new_rt;
      int  old_phase;
      bit  rise, fall, hit;
      logic [3:0] fresh;
      if (!rst_n) begin
         m_phase = P_IDLE; m_score = 0; m_lives = 3; m_rt = 12; m_load_left = 0;
         m_target = 4'd1; m_lfsr = 8'hA5; m_prev_tick = 1'b1; m_prev_keys = 4'd0;
         m_open = 1'b0; m_got = 1'b0; m_got_val = 4'd0;
         return;
      end
      old_phase = m_phase;
      new_rt    = (m_phase == P_LOAD) ? 12 : rt_rule(m_score);
      fresh     = fresh_target();
      case (m_phase)
         P_IDLE, P_OVER: begin
            if (start) begin
               m_phase     = P_LOAD;
               m_load_left = 4;
            end
         end
         P_LOAD: begin
            m_score = 0;
            m_lives = 3;
            m_load_left--;
            if (m_load_left == 0) begin
               m_phase  = P_PLAY;
               m_target = fresh;
               m_open   = 1'b1;
               m_got    = 1'b0;
            end
         end
         default: begin
            rise = round_tick && !m_prev_tick;
            fall = !round_tick && m_prev_tick;
            if (rise) begin
               m_target = fresh;
               m_open   = 1'b1;
               m_got    = 1'b0;
            end
            if (keys != 4'd0 && m_prev_keys == 4'd0 && round_tick && m_open && !m_got) begin
               m_got     = 1'b1;
               m_got_val = keys;
            end
            if (fall && m_open) begin
               m_open = 1'b0;
               hit    = m_got && (m_got_val == m_target);
               if (hit) begin
                  if (m_score < 255) m_score++;
               end else begin
                  m_lives--;
                  if (m_lives == 0) m_phase = P_OVER;
               end
               n_round++;
               $display("round %0d %s: score=%0d lives=%0d", n_round, hit ? "hit" : "miss",
                        m_score, m_lives);
            end
         end
      endcase
      m_prev_tick = (old_phase == P_PLAY) ? round_tick : 1'b1;
      m_prev_keys = keys;
      m_rt        = new_rt;
      m_lfsr      = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
      end
   endtask

   task automatic check_all();
      chk("gameState", 8'(gameState), 8'(m_phase == P_PLAY));
      chk("INIT", 8'(INIT), 8'(m_phase != P_PLAY));
      chk("game_over", 8'(game_over), 8'(m_phase == P_OVER));
      chk("roundTime", 8'(roundTime), 8'(m_rt));
      chk("target", 8'(target), 8'(m_target));
      chk("target_nonzero", 8'(target != 4'd0), 8'd1);
      chk("score", score, 8'(m_score));
      chk("lives", 8'(lives), 8'(m_lives));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic begin_game();
      round_tick = 1'b1;
      start      = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 12 && m_phase != P_PLAY; i++) step();
      chk("entered_play", 8'(gameState), 8'd1);
   endtask

   task automatic play_round(input int kind, input bit rise_first);
      logic [3:0] w;
      if (rise_first) begin
         round_tick = 1'b1;
         if (kind == K_RISE_PRESS) keys = fresh_target();
         step();
         keys = 4'd0;
      end
      repeat ($urandom_range(0, 2)) step();
      w = wrong_pattern(m_target);
      case (kind)
         K_HIT: begin
            keys = m_target;
            repeat ($urandom_range(1, 2)) step();
            keys = 4'd0;
            step();
         end
         K_WRONG: begin
            keys = w; step(); keys = 4'd0; step();
         end
         K_WRONG_RIGHT: begin
            keys = w;        step(); keys = 4'd0; step();
            keys = m_target; step(); keys = 4'd0; step();
         end
         default: step();
      endcase
      round_tick = 1'b0;
      if (kind == K_FALL_PRESS) keys = m_target;
      step();
      keys = 4'd0;
      repeat ($urandom_range(1, 3)) step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; keys = 4'd0; round_tick = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();

      // game 1: five hits, start ignored while playing, then reset mid-game
      begin_game();
      play_round(K_HIT, 1'b0);
      for (int i = 0; i < 4; i++) play_round(K_HIT, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      chk("score_before_reset", score, 8'd5);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      step();

      // game 2: wrong-then-right, press on fall, press on rise, then random rounds
      begin_game();
      play_round(K_WRONG_RIGHT, 1'b0);
      play_round(K_FALL_PRESS, 1'b1);
      play_round(K_RISE_PRESS, 1'b1);
      for (int i = 0; i < 40 && m_phase != P_OVER; i++) begin
         k = $urandom_range(0, 9);
         if (k <= 5)      play_round(K_HIT, 1'b1);
         else if (k == 6) play_round(K_RISE_PRESS, 1'b1);
         else if (k == 7) play_round(K_WRONG, 1'b1);
         else if (k == 8) play_round(K_NONE, 1'b1);
         else             play_round(K_WRONG_RIGHT, 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         round_tick = 1'($urandom_range(0, 1));
         keys       = 4'($urandom_range(0, 15));
         step();
      end
      keys = 4'd0;

      // game 3: three silent windows end the game
      begin_game();
      play_round(K_NONE, 1'b0);
      play_round(K_NONE, 1'b1);
      play_round(K_NONE, 1'b1);
      chk("over_after_three_misses", 8'(game_over), 8'd1);
      step();

      // game 4: run the score into saturation
      begin_game();
      play_round(K_HIT, 1'b0);
      for (int i = 0; i < 259; i++) play_round(K_HIT, 1'b1);
      chk("score_saturated", score, 8'd255);
      chk("roundTime_floor", 8'(roundTime), 8'd4);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
